// File: rtl/sigma_delta_dac.sv
// sigma_delta_dac: PCM to 1-bit PDM converter running at the bit clock (BCLK).
// One unsigned offset-binary sample is pulled every BOSR clocks through a
// valid/ready holding register. The sample is interpolated by BOSR with a
// STGS-stage CIC interpolator and then drives a first-order sigma-delta
// modulator. An external RC low-pass on pdm_out reconstructs the analog signal.
//
// Ports:
//   clk       bit clock (BCLK = sample clock * BOSR)
//   rst_n     asynchronous active-low reset
//   dac_input PCM sample, unsigned offset binary (mid-scale = 2^(DWDTH-1))
//   dac_valid dac_input valid
//   dac_ready holding register empty, a sample can be accepted
//   pdm_out   registered 1-bit PDM stream
//   underrun  one-cycle pulse when a consume strobe finds the holding register empty
module sigma_delta_dac #(
    parameter int BOSR  = 256,
    parameter int STGS  = 2,
    parameter int DWDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DWDTH-1:0] dac_input,
    input  logic             dac_valid,
    output logic             dac_ready,
    output logic             pdm_out,
    output logic             underrun
);

    localparam int LB = $clog2(BOSR);
    localparam int IW = DWDTH + STGS * LB;
    localparam int SH = (STGS - 1) * LB;

    logic [LB-1:0]          ph;
    logic                   strobe;
    logic                   accept;
    logic [DWDTH-1:0]       hold_q;
    logic                   hold_full;
    logic [DWDTH-1:0]       cur;
    logic [DWDTH-1:0]       s;
    logic                   st_d;
    logic                   upd;
    logic signed [IW-1:0]   comb_x   [STGS+1];
    logic signed [IW-1:0]   comb_dly [STGS];
    logic signed [IW-1:0]   comb_q;
    logic signed [IW-1:0]   int_in;
    logic signed [IW-1:0]   integ    [STGS];
    logic signed [IW-1:0]   int_sh;
    logic [DWDTH-1:0]       y;
    logic [DWDTH-1:0]       u;
    logic [DWDTH:0]         acc;

    assign strobe    = (ph == LB'(BOSR - 1));
    assign dac_ready = !hold_full;
    assign accept    = dac_valid && dac_ready;
    // Combinational so the pulse lines up with the strobe cycle itself; ph is
    // cleared by reset, so this is also 0 while reset is held.
    assign underrun  = strobe && !hold_full;

    // Phase counter and sample handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph        <= '0;
            hold_q    <= '0;
            hold_full <= 1'b0;
            cur       <= '0;
        end else begin
            ph <= ph + LB'(1);
            if (accept) begin
                hold_q <= dac_input;
            end
            // hold_full = 1 blocks accept, so consume and accept never collide.
            if (strobe && hold_full) begin
                cur       <= hold_q;
                hold_full <= 1'b0;
            end else if (accept) begin
                hold_full <= 1'b1;
            end
        end
    end

    // Offset binary to two's complement, then the comb differentiators.
    assign s = {~cur[DWDTH-1], cur[DWDTH-2:0]};

    always_comb begin
        comb_x[0] = {{(IW - DWDTH){s[DWDTH-1]}}, s};
        for (int unsigned i = 0; i < STGS; i++) begin
            comb_x[i+1] = comb_x[i] - comb_dly[i];
        end
    end

    // Zero-stuffing upsampler: the comb result enters the integrators for one cycle.
    assign int_in = upd ? comb_q : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_d   <= 1'b0;
            upd    <= 1'b0;
            comb_q <= '0;
            for (int unsigned i = 0; i < STGS; i++) begin
                comb_dly[i] <= '0;
                integ[i]    <= '0;
            end
        end else begin
            st_d <= strobe;
            upd  <= st_d;
            if (st_d) begin
                comb_q <= comb_x[STGS];
                for (int unsigned i = 0; i < STGS; i++) begin
                    comb_dly[i] <= comb_x[i];
                end
            end
            // Wrap-around arithmetic is intentional: CIC integrators rely on it.
            integ[0] <= integ[0] + int_in;
            for (int unsigned i = 1; i < STGS; i++) begin
                integ[i] <= integ[i] + integ[i-1];
            end
        end
    end

    // Remove the BOSR^(STGS-1) DC gain and return to offset binary.
    assign int_sh = integ[STGS-1] >>> SH;
    assign y      = int_sh[DWDTH-1:0];
    assign u      = {~y[DWDTH-1], y[DWDTH-2:0]};

    // First-order modulator: the carry out of the accumulator is the PDM bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            pdm_out <= 1'b0;
        end else begin
            acc     <= {1'b0, acc[DWDTH-1:0]} + {1'b0, u};
            pdm_out <= acc[DWDTH];
        end
    end

endmodule

// File: tb/tb_sigma_delta_dac.sv
module tb_sigma_delta_dac;

    localparam int BOSR  = 256;
    localparam int STGS  = 2;
    localparam int DWDTH = 16;
    localparam int FS    = 1 << DWDTH;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] dac_input = '0;
    logic        dac_valid = 1'b0;
    logic        dac_ready;
    logic        pdm_out;
    logic        underrun;

    always #5 clk = ~clk;

    sigma_delta_dac #(.BOSR(BOSR), .STGS(STGS), .DWDTH(DWDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .dac_input (dac_input),
        .dac_valid (dac_valid),
        .dac_ready (dac_ready),
        .pdm_out   (pdm_out),
        .underrun  (underrun)
    );

    typedef struct {
        logic [15:0] val;
        int          lo;
        int          hi;
        string       nm;
    } vec_t;

    vec_t vecs [7];

    int total = 0;
    int bad   = 0;
    int cyc, ones, ur_cnt, low_run, last_xfer, xfer_ign, run_ign;
    bit ur_prev, stream_chk;

    task automatic check(input string name, input int act, input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: got timeout, want event within bound", name);
    endtask

    // One clock; outputs are sampled 1 time unit after the rising edge.
    // cyc counts edges since reset release, so the expected phase is cyc % BOSR.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (pdm_out) ones++;
        if (underrun) begin
            ur_cnt++;
            check("underrun_phase", cyc % BOSR, BOSR - 1, BOSR - 1);
            check("underrun_width", int'(ur_prev), 0, 0);
        end
        ur_prev = underrun;
        if (!dac_ready) begin
            low_run++;
        end else begin
            if (stream_chk && low_run != 0) begin
                if (run_ign > 0) run_ign--;
                else check("ready_low_run", low_run, BOSR - 1, BOSR - 1);
            end
            low_run = 0;
        end
        if (stream_chk && dac_ready && dac_valid) begin
            if (last_xfer >= 0) begin
                if (xfer_ign > 0) xfer_ign--;
                else check("xfer_spacing", cyc - last_xfer, BOSR, BOSR);
            end
            last_xfer = cyc;
        end
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic clear_mon();
        cyc = 0; ones = 0; ur_cnt = 0; low_run = 0; last_xfer = -1;
        xfer_ign = 1; run_ign = 1; ur_prev = 1'b0;
    endtask

    task automatic wait_ph(input int target, input string name);
        int n;
        n = 0;
        while (cyc % BOSR != target && n < 2 * BOSR) begin
            tick();
            n++;
        end
        if (cyc % BOSR != target) timeout(name);
    endtask

    // Stream a constant with valid held high, let the filter settle, then
    // count ones over one 256-clock window.
    task automatic stream(input logic [15:0] v, input string nm, input int lo, input int hi);
        dac_input = v;
        dac_valid = 1'b1;
        if (!stream_chk) begin
            stream_chk = 1'b1;
            last_xfer = -1;
            xfer_ign = 1;
            run_ign = 1;
        end
        ur_cnt = 0;
        run(4 * BOSR);
        ones = 0;
        run(256);
        check(nm, ones, lo, hi);
        check({nm, "_no_underrun"}, ur_cnt, 0, 0);
    endtask

    // Reference for a fresh start: the filter state is zero, i.e. mid-scale,
    // so the first window is the modulator running at u = 2^(DWDTH-1) from acc = 0.
    function automatic int fresh_ones();
        int a, c;
        a = 0;
        c = 0;
        for (int k = 0; k < 256; k++) begin
            c += (a / FS) % 2;
            a = (a % FS) + FS / 2;
        end
        return c;
    endfunction

    initial begin
        int exp_fresh, lo, c;
        logic [15:0] v;

        vecs[0] = '{16'h8000, 127, 129, "dens_8000"};
        vecs[1] = '{16'h4000,  63,  65, "dens_4000"};
        vecs[2] = '{16'hC000, 191, 193, "dens_C000"};
        vecs[3] = '{16'h2000,  31,  33, "dens_2000"};
        vecs[4] = '{16'hE000, 223, 225, "dens_E000"};
        vecs[5] = '{16'h6000,  95,  97, "dens_6000"};
        vecs[6] = '{16'hA000, 159, 161, "dens_A000"};
        exp_fresh = fresh_ones();
        stream_chk = 1'b0;
        clear_mon();

        // Reset state; valid is ignored while reset is held.
        #2 rst_n = 1'b0;
        #1;
        check("rst_pdm", int'(pdm_out), 0, 0);
        check("rst_underrun", int'(underrun), 0, 0);
        check("rst_ready", int'(dac_ready), 1, 1);
        dac_input = 16'h8000;
        dac_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready_valid_ignored", int'(dac_ready), 1, 1);
        @(negedge clk);
        rst_n = 1'b1;
        clear_mon();

        // First transfer is in the cycle right after release.
        tick();
        check("first_xfer", int'(dac_ready), 0, 0);
        run(255);
        check("fresh_window", ones, exp_fresh, exp_fresh);

        // Table of constant levels with valid held high.
        for (int i = 0; i < 7; i++) begin
            stream(vecs[i].val, vecs[i].nm, vecs[i].lo, vecs[i].hi);
        end

        // Underrun: stop feeding just after a transfer; one strobe consumes the
        // held sample, the next four find it empty and repeat the last sample.
        stream_chk = 1'b0;
        wait_ph(1, "wait_ph1");
        check("ur_hold_full", int'(dac_ready), 0, 0);
        dac_valid = 1'b0;
        ur_cnt = 0;
        run(5 * BOSR);
        check("underrun_count", ur_cnt, 4, 4);
        ones = 0;
        run(256);
        check("ur_dens_A000", ones, 159, 161);

        // Accept in the strobe cycle with the holding register empty.
        wait_ph(BOSR - 1, "wait_strobe");
        check("sa_underrun", int'(underrun), 1, 1);
        check("sa_ready", int'(dac_ready), 1, 1);
        dac_input = 16'h6000;
        dac_valid = 1'b1;
        tick();
        dac_valid = 1'b0;
        dac_input = 16'h0000;
        check("sa_accepted", int'(dac_ready), 0, 0);
        run(BOSR - 1);
        check("sa_consume_no_ur", int'(underrun), 0, 0);
        tick();
        check("sa_ready_after", int'(dac_ready), 1, 1);
        run(4 * BOSR);
        ones = 0;
        run(256);
        check("sa_dens_6000", ones, 95, 97);

        // Randomized constant levels against the ideal density u * 256 / 2^16.
        for (int i = 0; i < 6; i++) begin
            v = 16'($urandom_range(16'hE000, 16'h2000));
            lo = (int'(v) * 256) / FS;
            stream(v, "rand_dens", lo, lo + 1);
        end

        // Asynchronous reset mid-stream.
        stream_chk = 1'b0;
        dac_input = 16'hA000;
        dac_valid = 1'b1;
        run(300);
        #3 rst_n = 1'b0;
        #1;
        check("mid_rst_pdm", int'(pdm_out), 0, 0);
        check("mid_rst_underrun", int'(underrun), 0, 0);
        check("mid_rst_ready", int'(dac_ready), 1, 1);
        @(posedge clk);
        #1;
        check("mid_rst_ready_hold", int'(dac_ready), 1, 1);
        @(negedge clk);
        rst_n = 1'b1;
        clear_mon();
        tick();
        check("post_rst_first_xfer", int'(dac_ready), 0, 0);
        run(255);
        check("post_rst_window", ones, exp_fresh, exp_fresh);
        run(3 * BOSR);
        ones = 0;
        run(256);
        check("post_rst_dens_A000", ones, 159, 161);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute guard so the run always ends.
    initial begin
        #5000000;
        $display("FAIL global_timeout: got no finish, want finish");
        $fatal(1, "timeout");
    end

endmodule
